// File: rtl/noc_pkg.sv
// noc_pkg: shared port codes, sizes, arbiter states and mod-5 index helper
package noc_pkg;
  localparam int NPORTS = 5;
  localparam int SEL_W = 3;
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_W = 3'd2,
    PORT_E = 3'd3,
    PORT_L = 3'd4
  } port_e;
  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;
  function automatic logic [2:0] inc5(input logic [2:0] p, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, k};
    s = (s >= 4'd5) ? s - 4'd5 : s;
    return s[2:0];
  endfunction
endpackage

// File: rtl/rr_pick5.sv
// rr_pick5: first requester at or after ptr_i, ascending with wrap 4->0
module rr_pick5
  import noc_pkg::*;
(
  input  logic [4:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [2:0] win_o,
  output logic       found_o
);
  always_comb begin
    found_o = 1'b0;
    win_o = ptr_i;
    for (int i = 4; i >= 0; i--) begin
      if (req_i[inc5(ptr_i, 3'(i))]) begin
        found_o = 1'b1;
        win_o = inc5(ptr_i, 3'(i));
      end
    end
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: packet-locked round-robin arbiter for one 5-input output port
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int SEL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NPORTS-1:0] req_i,
  input  logic [NPORTS-1:0] tail_i,
  input  logic              ready_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              valid_o,
  output logic              xfer_o
);
  arb_state_e state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] win;
  logic found;
  rr_pick5 u_pick (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .win_o  (win),
    .found_o(found)
  );
  // owner doubles as the crossbar select so the path only moves on a new lock
  assign sel_o = owner_q;
  assign gnt_o = (state_q == ST_LOCKED) ? {{(NPORTS-1){1'b0}}, 1'b1} << owner_q : '0;
  assign valid_o = (state_q == ST_LOCKED) && req_i[owner_q];
  assign xfer_o = valid_o && ready_i;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && found) begin
      state_d = ST_LOCKED;
      owner_d = win;
    end else if (state_q == ST_LOCKED && xfer_o && tail_i[owner_q]) begin
      state_d = ST_IDLE;
      ptr_d = inc5(owner_q, 3'd1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
    end
  end
endmodule
